// File: rtl/shift_req_stage_pkg.sv
// Shared types and helpers for the shift request stage and its barrel shifter.
package shift_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned AMT_W  = 3;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amt;
    } shift_req_t;

    // Ones in the top amt bits mark the bits that fall off the left edge.
    function automatic logic lost_bits(input logic [DATA_W-1:0] data,
                                       input logic [AMT_W-1:0]  amt);
        logic [DATA_W-1:0] mask;
        mask = ~({DATA_W{1'b1}} >> amt);
        return |(data & mask);
    endfunction

endpackage

// File: rtl/shift_req_stage_barrel_shift.sv
// Combinational logarithmic left barrel shifter, zero fill, truncated to DATA_W.
module barrel_shift
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    input  logic [AMT_W-1:0]  shift_amount,
    output logic [DATA_W-1:0] data_out_c
);

    logic [DATA_W-1:0] stage;

    // One conditional power-of-two shift per amount bit.
    always_comb begin
        stage = data_in;
        for (int unsigned i = 0; i < AMT_W; i++) begin
            if (shift_amount[i]) begin
                stage = stage << (1 << i);
            end
        end
        data_out_c = stage;
    end

endmodule

// File: rtl/shift_req_stage.sv
// Request FIFO + registered result stage wrapped around barrel_shift,
// with valid/ready handshakes on both sides and a completed-operation counter.
module shift_req_stage
    import shift_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [AMT_W-1:0]  out_amt,
    output logic              out_lost,
    output logic [CNT_W-1:0]  done_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FILL_W = $clog2(DEPTH + 1);

    shift_req_t        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FILL_W-1:0] count;

    shift_req_t        wr_req;
    shift_req_t        head;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] shift_res;

    // in_ready depends only on registered count, so a pop cannot free a slot this cycle.
    assign in_ready = (count != FILL_W'(DEPTH));
    assign push     = in_valid & in_ready;
    assign pop      = (count != '0) & (~out_valid | out_ready);
    assign wr_req   = '{data: in_data, amt: in_amt};
    assign head     = mem[rd_ptr];

    barrel_shift u_shift (
        .data_in      (head.data),
        .shift_amount (head.amt),
        .data_out_c   (shift_res)
    );

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
            out_lost  <= 1'b0;
            done_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + FILL_W'(1);
                2'b01:   count <= count - FILL_W'(1);
                default: count <= count;
            endcase

            if (pop) begin
                out_valid <= 1'b1;
                out_data  <= shift_res;
                out_amt   <= head.amt;
                out_lost  <= lost_bits(head.data, head.amt);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (out_valid && out_ready) begin
                done_cnt <= done_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_shift_req_stage.sv
// Directed self-checking bench for shift_req_stage (DEPTH=2, CNT_W=8).
module tb_shift_req_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_amt;
    logic       out_lost;
    logic [7:0] done_cnt;

    int checks = 0;
    int errors = 0;

    shift_req_stage #(.DEPTH(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_amt   (out_amt),
        .out_lost  (out_lost),
        .done_cnt  (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] a);
        in_valid = v;
        in_data  = d;
        in_amt   = a;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'h00, 3'd0);
        out_ready = 1'b0;

        // 1. reset asserted before any clock edge
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        step();
        step();
        rst = 1'b0;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_data", out_data, 0);
        chk("post_rst_out_valid", out_valid, 0);

        // 2. single request, latency
        out_ready = 1'b1;
        drive(1'b1, 8'hFF, 3'd3);
        step();
        drive(1'b0, 8'h00, 3'd0);
        chk("single_not_yet", out_valid, 0);
        step();
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 8'hF8);
        chk("single_amt", out_amt, 3);
        chk("single_lost", out_lost, 1);
        chk("single_cnt_before", done_cnt, 0);
        step();
        chk("single_drained", out_valid, 0);
        chk("single_cnt", done_cnt, 1);

        // 3. back-to-back stream, out_ready held high
        drive(1'b1, 8'hFF, 3'd0);
        step();
        drive(1'b1, 8'hFF, 3'd3);
        step();
        chk("b2b0_data", out_data, 8'hFF);
        chk("b2b0_lost", out_lost, 0);
        drive(1'b1, 8'hFF, 3'd5);
        step();
        chk("b2b1_data", out_data, 8'hF8);
        chk("b2b1_lost", out_lost, 1);
        drive(1'b1, 8'hFF, 3'd7);
        step();
        chk("b2b2_data", out_data, 8'hE0);
        chk("b2b2_lost", out_lost, 1);
        chk("b2b2_valid", out_valid, 1);
        drive(1'b0, 8'h00, 3'd0);
        step();
        chk("b2b3_data", out_data, 8'h80);
        chk("b2b3_lost", out_lost, 1);
        chk("b2b3_amt", out_amt, 7);
        step();
        chk("b2b_drained", out_valid, 0);
        chk("b2b_cnt", done_cnt, 5);

        // 4. backpressure fills FIFO plus output register
        out_ready = 1'b0;
        drive(1'b1, 8'h01, 3'd1);
        step();
        drive(1'b1, 8'h01, 3'd2);
        step();
        chk("bp_first_out", out_data, 8'h02);
        chk("bp_in_ready_mid", in_ready, 1);
        drive(1'b1, 8'h01, 3'd3);
        step();
        drive(1'b0, 8'h00, 3'd0);
        chk("bp_full_in_ready", in_ready, 0);
        chk("bp_hold_data", out_data, 8'h02);
        step();
        chk("bp_hold_data2", out_data, 8'h02);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_cnt", done_cnt, 5);
        out_ready = 1'b1;
        step();
        chk("bp_out1", out_data, 8'h04);
        chk("bp_in_ready_back", in_ready, 1);
        chk("bp_cnt1", done_cnt, 6);
        step();
        chk("bp_out2", out_data, 8'h08);
        chk("bp_out2_amt", out_amt, 3);
        step();
        chk("bp_drained", out_valid, 0);
        chk("bp_cnt", done_cnt, 8);

        // 5. lost-bit boundaries
        drive(1'b1, 8'h0F, 3'd4);
        step();
        drive(1'b1, 8'h1F, 3'd4);
        step();
        chk("lb0_data", out_data, 8'hF0);
        chk("lb0_lost", out_lost, 0);
        drive(1'b1, 8'h80, 3'd0);
        step();
        chk("lb1_data", out_data, 8'hF0);
        chk("lb1_lost", out_lost, 1);
        drive(1'b0, 8'h00, 3'd0);
        step();
        chk("lb2_data", out_data, 8'h80);
        chk("lb2_lost", out_lost, 0);
        step();
        chk("lb_cnt", done_cnt, 11);

        // 6. asynchronous reset with FIFO full and output valid
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 3'd1);
        step();
        drive(1'b1, 8'h22, 3'd1);
        step();
        drive(1'b1, 8'h33, 3'd1);
        step();
        drive(1'b0, 8'h00, 3'd0);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        chk("full_out_data", out_data, 8'h22);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_amt", out_amt, 0);
        chk("arst_done_cnt", done_cnt, 0);
        chk("arst_in_ready", in_ready, 1);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("arst_discard", out_valid, 0);
        drive(1'b1, 8'h03, 3'd2);
        step();
        drive(1'b0, 8'h00, 3'd0);
        step();
        chk("arst_new_valid", out_valid, 1);
        chk("arst_new_data", out_data, 8'h0C);
        chk("arst_new_lost", out_lost, 0);
        step();
        chk("arst_new_cnt", done_cnt, 1);
        chk("arst_new_drained", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_req_stage.md
Name: shift_req_stage

Overview:
- Registered request/response front-end for the 8-bit combinational left barrel shifter `barrel_shift`.
- Buffers incoming shift requests (data, amount) in a small FIFO and presents the FIFO head to `barrel_shift`.
- Captures the shifted result, plus a lost-bits flag, in an output register with valid/ready handshakes on both sides.
- Sits directly upstream of the shifter and wraps it, so downstream logic sees a pipelined, back-pressurable shift unit.

Parameters:
- DEPTH, 2, request FIFO entries; power of two, ≥2.
- CNT_W, 8, width of completed-operation counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid & in_ready at clk edge
- in_data  input  8  operand
- in_amt  input  3  left-shift amount 0..7
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts when out_valid & out_ready
- out_data  output  8  in_data << in_amt, truncated to 8 bits
- out_amt  output  3  echo of request amount
- out_lost  output  1  1 if any 1-bit was shifted out of bit 7
- done_cnt  output  CNT_W  count of completed output handshakes, wraps modulo 2^CNT_W

Behaviour:
- Interface (already decided): one clock, `clk`. Reset `rst` is asynchronous and active-high.
- While rst=1, all state clears immediately:
  - FIFO count and pointers = 0
  - out_valid = 0, out_data = 0, out_amt = 0, out_lost = 0, done_cnt = 0
  - in_ready = 1 once rst deasserts
- Any request in flight when rst asserts is discarded; nothing is flushed to the output.
- in_ready = (count != DEPTH), combinational from registered count only.
  - At full, a same-cycle pop does not allow a push.
- Push: on in_valid & in_ready, write {in_data, in_amt} at wr_ptr; wr_ptr increments and wraps at DEPTH.
- Pop condition: count != 0 & (!out_valid | out_ready).
  - Output register loads the shifter result for the head entry: barrel_shift(data_in = head.data, shift_amount = head.amt).
  - Loaded fields: out_data, out_amt = head.amt, out_lost.
  - out_valid <= 1; rd_ptr increments and wraps.
- No pop and out_valid & out_ready: out_valid <= 0.
- out_* hold stable while out_valid & !out_ready.
- count update:
  - +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Push and pop may coincide when 0 < count < DEPTH.
  - Push into an empty FIFO is not popped in the same cycle; the FIFO has no bypass.
- Latency: a request accepted at edge k produces out_valid=1 after edge k+1 at the earliest.
- Throughput: one result per cycle when out_ready is held high.
- Ordering: strict FIFO; results appear in acceptance order.
- out_lost computation:
  - amt=0 → 0
  - otherwise → OR of data[7 : 8-amt]
- done_cnt increments on every out_valid & out_ready handshake; wraps to 0 after all-ones.
- Total buffered requests = count + out_valid, at most DEPTH+1.

Decomposition:
- Package shift_pkg:
  - localparam DATA_W=8, AMT_W=3
  - typedef struct packed {logic [DATA_W-1:0] data; logic [AMT_W-1:0] amt;} shift_req_t
  - function lost_bits(data, amt)
- Sub-module: existing `barrel_shift`, instantiated once on the FIFO head.
- FIFO storage and pointers stay inline; no separate FIFO module.

Test Plan:
1. Reset: assert rst for 2 cycles mid-clock → out_valid=0, in_ready=1, done_cnt=0 with no clock edge required.
2. Single request with out_ready=1: in_data=0xFF, in_amt=3 → out_data=0xF8, out_amt=3, out_lost=1; out_valid high 2 edges after accept; done_cnt=1.
3. Back-to-back with out_ready=1: 0xFF at amt 0,3,5,7 on consecutive cycles → out_data FF,F8,E0,80 on consecutive cycles; out_lost 0,1,1,1; done_cnt=4.
4. Backpressure with out_ready=0: push 0x01 at amt 1,2,3 → out_data holds 0x02; in_ready drops after third accept (DEPTH=2). Then raise out_ready → outputs 02,04,08 in order; in_ready returns to 1.
5. Lost-bit boundary: 0x0F amt 4 → F0, lost=0; 0x1F amt 4 → F0, lost=1; 0x80 amt 0 → 80, lost=0.
6. Reset mid-operation: with FIFO full and out_valid=1, pulse rst asynchronously → outputs clear immediately. A new request 0x03 amt 2 then yields 0x0C and done_cnt=1.
